// File: rtl/hazard_controller.sv
// Hazard controller for the in-order pipeline.
// Detects load-use hazards, sequences multi-cycle MDU operations with a
// watchdog timeout, and squashes the wrong-path instructions after a taken
// branch. The stall_cnt output counts cycles in which the PC is frozen.
module hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MDU_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic [6:0]  ifid_opcode,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic        ex_mdu_req,
  input  logic        mdu_done,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        mdu_start,
  output logic        mdu_error,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // The branch cycle itself is the first squash cycle, so FLUSH only has
  // to cover the remaining FLUSH_CYCLES-1 cycles.
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);
  localparam logic [7:0] BUSY_LAST    = 8'(MDU_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        mdu_error_q, mdu_error_d;

  logic        rs2_used;
  logic        load_use;

  // Decode whether the ID instruction reads rs2, then detect a load-use hazard.
  always_comb begin
    rs2_used = 1'b0;
    case (ifid_opcode)
      7'b0110011,
      7'b0100011,
      7'b1100011,
      7'b1010011,
      7'b0100111: rs2_used = 1'b1;
      default:    rs2_used = 1'b0;
    endcase

    load_use = idex_memread && (idex_rd != 5'd0) &&
               ((idex_rd == ifid_rs1) || (rs2_used && (idex_rd == ifid_rs2)));
  end

  // Pipeline control outputs and next-state logic; outputs sit at their
  // defaults while reset is held so a stalled MDU releases the pipe at once.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    mdu_start   = 1'b0;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    mdu_error_d = mdu_error_q;

    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_MULTI) begin
              state_d     = FLUSH;
              flush_cnt_d = FLUSH_RELOAD;
            end
          end else if (ex_mdu_req) begin
            mdu_start  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            state_d    = MDU_BUSY;
            busy_cnt_d = 8'd0;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end

        MDU_BUSY: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          exmem_hold = 1'b1;
          if (mdu_done) begin
            state_d = RUN;
          end else if (busy_cnt_q == BUSY_LAST) begin
            mdu_error_d = 1'b1;
            state_d     = RUN;
          end else begin
            busy_cnt_d = busy_cnt_q + 8'd1;
          end
        end

        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (branch_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
          end else if (flush_cnt_q == 4'd1) begin
            flush_cnt_d = 4'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State, counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 4'd0;
      busy_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      mdu_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mdu_error_q <= mdu_error_d;
    end
  end

  assign mdu_error = mdu_error_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a driver applies one stimulus per
// cycle and queues the behaviour expected from a pipeline-level model; a
// monitor pops and compares the DUT outputs each cycle.
module tb_hazard_controller;

  localparam int FC = 2;
  localparam int MT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ifid_rs1 = '0;
  logic [4:0]  ifid_rs2 = '0;
  logic [6:0]  ifid_opcode = 7'b0010011;
  logic        idex_memread = 1'b0;
  logic [4:0]  idex_rd = '0;
  logic        ex_mdu_req = 1'b0;
  logic        mdu_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic        exmem_hold, mdu_start, mdu_error;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_hold;
    logic        mdu_start;
    logic        mdu_error;
    logic [15:0] stall_cnt;
  } obs_t;

  obs_t  exp_q[$];
  string phase_q[$];
  int    checks = 0;
  int    passes = 0;
  string phase = "reset";

  // Pipeline-level model: how many squash cycles remain, whether an MDU
  // operation is outstanding and for how long, the error flag, stall total.
  int m_flush_left = 0;
  bit m_mdu_on = 0;
  int m_mdu_cycles = 0;
  bit m_err = 0;
  int m_stalls = 0;

  hazard_controller #(.FLUSH_CYCLES(FC), .MDU_TIMEOUT(MT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_opcode(ifid_opcode),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_mdu_req(ex_mdu_req), .mdu_done(mdu_done), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .mdu_start(mdu_start),
    .mdu_error(mdu_error), .stall_cnt(stall_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic bit hazard(input bit mrd, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [6:0] op);
    bit reads_rs2;
    reads_rs2 = op inside {7'b0110011, 7'b0100011, 7'b1100011,
                           7'b1010011, 7'b0100111};
    return mrd && (rd != 0) && (rd == rs1 || (reads_rs2 && rd == rs2));
  endfunction

  task automatic applyStimulus(input bit rst, input bit br, input bit mreq,
                               input bit done, input bit mrd,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [6:0] op);
    obs_t e;
    @(negedge clk);
    rst_n = rst; branch_taken = br; ex_mdu_req = mreq; mdu_done = done;
    idex_memread = mrd; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    ifid_opcode = op;
    e = '0;
    e.pc_write = 1'b1;
    e.ifid_write = 1'b1;
    if (!rst) begin
      m_flush_left = 0; m_mdu_on = 0; m_mdu_cycles = 0; m_err = 0; m_stalls = 0;
    end else begin
      e.mdu_error = m_err;
      e.stall_cnt = 16'(m_stalls);
      if (m_mdu_on) begin
        e.pc_write = 0; e.ifid_write = 0; e.exmem_hold = 1;
        m_mdu_cycles++;
        if (done) m_mdu_on = 0;
        else if (m_mdu_cycles == MT) begin m_err = 1; m_mdu_on = 0; end
      end else if (m_flush_left > 0) begin
        e.ifid_flush = 1; e.idex_bubble = 1;
        m_flush_left = br ? FC - 1 : m_flush_left - 1;
      end else if (br) begin
        e.ifid_flush = 1; e.idex_bubble = 1;
        m_flush_left = FC - 1;
      end else if (mreq) begin
        e.mdu_start = 1; e.pc_write = 0; e.ifid_write = 0; e.exmem_hold = 1;
        m_mdu_on = 1; m_mdu_cycles = 0;
      end else if (hazard(mrd, rd, rs1, rs2, op)) begin
        e.pc_write = 0; e.ifid_write = 0; e.idex_bubble = 1;
      end
      if (!e.pc_write && m_stalls < 65535) m_stalls++;
    end
    exp_q.push_back(e);
    phase_q.push_back(phase);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 7'b0010011);
  endtask

  task automatic checkOutput(input obs_t e, input string name);
    obs_t a;
    a = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold,
         mdu_start, mdu_error, stall_cnt};
    checks++;
    if (a === e) passes++;
    else $display("[TB] FAIL %s: got pc/ifw/fl/bub/hold/start/err=%b%b%b%b%b%b%b stall=%h, expected %b%b%b%b%b%b%b stall=%h",
                  name, a.pc_write, a.ifid_write, a.ifid_flush, a.idex_bubble,
                  a.exmem_hold, a.mdu_start, a.mdu_error, a.stall_cnt,
                  e.pc_write, e.ifid_write, e.ifid_flush, e.idex_bubble,
                  e.exmem_hold, e.mdu_start, e.mdu_error, e.stall_cnt);
  endtask

  // Monitor: compare each queued expectation shortly after it is issued.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) checkOutput(exp_q.pop_front(), phase_q.pop_front());
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [6:0] ops [6];
    ops[0] = 7'b0110011; ops[1] = 7'b0100011; ops[2] = 7'b1100011;
    ops[3] = 7'b0010011; ops[4] = 7'b0000011; ops[5] = 7'b1010011;

    phase = "reset";
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7'b0010011);
    applyStimulus(0, 1, 1, 0, 1, 5, 5, 5, 7'b0110011);
    idle(2);

    phase = "load_use_rs2";
    applyStimulus(1, 0, 0, 0, 1, 5, 0, 5, 7'b0110011);
    idle(2);

    phase = "no_false_hazard";
    applyStimulus(1, 0, 0, 0, 1, 5, 6, 5, 7'b0010011);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 7'b0110011);
    applyStimulus(1, 0, 0, 0, 1, 7, 7, 3, 7'b0010011);
    idle(1);

    phase = "mdu_done_5th";
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 7'b0110011);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 1, 2, 2, 2, 7'b0110011);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 7'b0010011);
    idle(2);

    phase = "mdu_timeout";
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 7'b0010011);
    for (int i = 0; i < MT + 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 7'b0010011);
    idle(3);

    phase = "branch_priority";
    applyStimulus(1, 1, 1, 0, 1, 5, 5, 0, 7'b0110011);
    applyStimulus(1, 0, 1, 0, 1, 5, 5, 0, 7'b0110011);
    idle(2);

    phase = "flush_reload";
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 7'b0010011);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 7'b0010011);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 7'b0010011);
    idle(2);

    phase = "reset_mid_mdu";
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 7'b0010011);
    idle(3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7'b0010011);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 7'b0010011);
    idle(3);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 5) == 0,
                    1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ops[$urandom_range(0, 5)]);
    end

    phase = "saturation";
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7'b0010011);
    for (int i = 0; i < 65537; i++) applyStimulus(1, 0, 0, 0, 1, 9, 9, 0, 7'b0010011);
    idle(3);

    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- FLUSH_CYCLES, 2, total cycles ifid_flush stays asserted per taken branch; legal range 1..15.
- MDU_TIMEOUT, 64, maximum MDU_BUSY cycles before abort; legal range 2..255.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifid_rs1  in  5  rs1 field of the instruction in ID.
- ifid_rs2  in  5  rs2 field of the instruction in ID.
- ifid_opcode  in  7  opcode of the instruction in ID.
- idex_memread  in  1  instruction in EX is a load (0000011 or 0000111).
- idex_rd  in  5  destination register of the instruction in EX.
- ex_mdu_req  in  1  instruction in EX is a multi-cycle mul/div/fdiv.
- mdu_done  in  1  multi-cycle unit result valid; a one-cycle pulse.
- branch_taken  in  1  EX resolved a taken branch or jump.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  zero IF/ID, inserting a NOP.
- idex_bubble  out  1  zero ID/EX control bits.
- exmem_hold  out  1  hold EX stage and EX/MEM while the MDU runs.
- mdu_start  out  1  one-cycle start pulse to the multi-cycle unit.
- mdu_error  out  1  sticky flag: MDU timeout occurred.
- stall_cnt  out  16  saturating count of cycles with pc_write=0.

Function
REQ-003 The FSM SHALL have exactly three states: RUN, MDU_BUSY and FLUSH.
REQ-004 Outputs SHALL be combinational from state and inputs; state, counters and mdu_error SHALL be registered.
REQ-005 Default outputs: pc_write=1, ifid_write=1, all other 1-bit outputs 0.
REQ-006 rs2_used SHALL be 1 when ifid_opcode is one of 0110011, 0100011, 1100011, 1010011 or 0100111, and 0 otherwise.
REQ-007 load_use SHALL be 1 when all of the following hold:
- idex_memread=1;
- idex_rd!=0;
- idex_rd==ifid_rs1, or (rs2_used and idex_rd==ifid_rs2).
REQ-008 RUN priority SHALL be branch_taken > ex_mdu_req > load_use.
REQ-009 RUN with branch_taken=1:
- ifid_flush=1 and idex_bubble=1 in the same cycle;
- if FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
REQ-010 RUN with ex_mdu_req=1 and branch_taken=0:
- mdu_start=1, pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0;
- go to MDU_BUSY with busy_cnt=0.
REQ-011 RUN with load_use=1 and no higher-priority event: pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle; stay in RUN.
REQ-012 MDU_BUSY outputs SHALL be pc_write=0, ifid_write=0, exmem_hold=1 and mdu_start=0 in every cycle, including the exit cycle.
REQ-013 MDU_BUSY with mdu_done=1 SHALL go to RUN.
REQ-014 MDU_BUSY with mdu_done=0 SHALL increment busy_cnt.
REQ-015 MDU_BUSY with busy_cnt==MDU_TIMEOUT-1 and mdu_done=0 SHALL set mdu_error=1 and go to RUN.
REQ-016 MDU_BUSY SHALL ignore branch_taken and load_use.
REQ-017 FLUSH SHALL drive ifid_flush=1 and idex_bubble=1, decrement flush_cnt, and go to RUN when flush_cnt==1.
REQ-018 FLUSH SHALL ignore load_use and ex_mdu_req, because the instructions are being squashed.
REQ-019 FLUSH with a new branch_taken SHALL reload flush_cnt=FLUSH_CYCLES-1.
REQ-020 stall_cnt SHALL increment on every cycle with pc_write=0 and saturate at 16'hFFFF without wrapping.
REQ-021 mdu_error SHALL clear only on reset.

Reset
REQ-022 On rst_n=0, asynchronously and regardless of state: state=RUN, flush_cnt=0, busy_cnt=0, stall_cnt=0, mdu_error=0.
REQ-023 While rst_n=0, outputs SHALL equal the REQ-005 defaults.
REQ-024 Reset asserted during MDU_BUSY SHALL drop the stall immediately, with no mdu_start re-issue after release.
REQ-025 The first rising edge after rst_n rises SHALL evaluate RUN rules.

Verification
REQ-026 Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_opcode=0110011 -> one cycle of pc_write=0, idex_bubble=1; stall_cnt=1.
REQ-027 No false hazard: same stimulus as REQ-026 with ifid_opcode=0010011 and ifid_rs1=6 -> no stall; also idex_rd=0 -> no stall.
REQ-028 MDU: ex_mdu_req=1, then mdu_done on the 5th MDU_BUSY cycle -> mdu_start high exactly 1 cycle, pc_write=0 for 6 cycles, back to RUN, stall_cnt=6.
REQ-029 Timeout: ex_mdu_req=1 with mdu_done never asserted, MDU_TIMEOUT=64 -> mdu_error=1 after 64 MDU_BUSY cycles, return to RUN, flag stays high.
REQ-030 Branch priority: branch_taken=1, ex_mdu_req=1 and load_use=1 together -> flush for 2 cycles, no mdu_start, no stall.
REQ-031 Reset mid-MDU_BUSY and saturation: rst_n low in MDU_BUSY -> outputs at defaults, stall_cnt=0; preload stall_cnt=16'hFFFE, apply 3 stall cycles -> stall_cnt holds at 16'hFFFF.
